// File: rtl/tick_timer_pkg.sv
// Shared types and default constants for the tick_timer block.
// Optional status counter is enabled with TICK_TIMER_STATUS_EN.
package tick_timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } tick_state_e;

   localparam int unsigned DEF_WIDTH  = 25;
   localparam int unsigned DEF_PERIOD = 25000000;

endpackage

// File: rtl/tick_timer_if.sv
// Control/status bundle between a timer user (master) and tick_timer (slave).
// tick_cnt and TickCntWidth exist only with TICK_TIMER_STATUS_EN.
interface tick_timer_if
   import tick_timer_pkg::*;
#(
   parameter int unsigned Width = DEF_WIDTH
`ifdef TICK_TIMER_STATUS_EN
   ,
   parameter int unsigned TickCntWidth = 8
`endif
);

   logic             start;
   logic             stop;
   logic             oneshot;
   logic             period_we;
   logic [Width-1:0] period_in;
   logic [Width-1:0] count;
   logic             tick;
   logic             busy;
   logic             done;
`ifdef TICK_TIMER_STATUS_EN
   logic [TickCntWidth-1:0] tick_cnt;
`endif

   modport master (
      output start, stop, oneshot, period_we, period_in,
`ifdef TICK_TIMER_STATUS_EN
      input  tick_cnt,
`endif
      input  count, tick, busy, done
   );

   modport slave (
      input  start, stop, oneshot, period_we, period_in,
`ifdef TICK_TIMER_STATUS_EN
      output tick_cnt,
`endif
      output count, tick, busy, done
   );

endinterface

// File: rtl/tick_timer_mod_counter.sv
// Width-parametrised counter: clears, counts when enabled, wraps to 0 once
// count >= period. Compare precedes increment so the count cannot overflow.
module mod_counter #(
   parameter int unsigned Width = 25
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_clr,
   input  logic             i_en,
   input  logic [Width-1:0] i_period,
   output logic [Width-1:0] o_count,
   output logic             o_wrap
);

   logic [Width-1:0] r_count;

   assign o_wrap  = i_en && (r_count >= i_period);
   assign o_count = r_count;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_count <= '0;
      end else if (i_en) begin
         r_count <= o_wrap ? '0 : r_count + Width'(1);
      end
   end

endmodule

// File: rtl/tick_timer.sv
// Programmable periodic/one-shot tick generator with start/stop and busy/done.
// TICK_TIMER_STATUS_EN adds a wrapping tick counter (bus.tick_cnt).
module tick_timer
   import tick_timer_pkg::*;
#(
   parameter int unsigned Width         = DEF_WIDTH,
   parameter int unsigned DefaultPeriod = DEF_PERIOD
`ifdef TICK_TIMER_STATUS_EN
   ,
   parameter int unsigned TickCntWidth  = 8
`endif
) (
   input  logic         i_clk,
   input  logic         i_rst,
   tick_timer_if.slave  bus
);

   tick_state_e      r_state;
   logic [Width-1:0] r_period;
   logic             r_mode;
   logic             r_tick;
   logic [Width-1:0] w_count;
   logic             w_wrap;
`ifdef TICK_TIMER_STATUS_EN
   logic [TickCntWidth-1:0] r_tick_cnt;
`endif

   // stop/start always restart the datapath from zero, cancelling a pending wrap
   mod_counter #(
      .Width (Width)
   ) u_counter (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_clr    (bus.stop || bus.start),
      .i_en     (r_state == ST_RUN),
      .i_period (r_period),
      .o_count  (w_count),
      .o_wrap   (w_wrap)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= ST_IDLE;
         r_period <= Width'(DefaultPeriod);
         r_mode   <= 1'b0;
         r_tick   <= 1'b0;
`ifdef TICK_TIMER_STATUS_EN
         r_tick_cnt <= '0;
`endif
      end else begin
         if (bus.period_we) begin
            r_period <= bus.period_in;
         end
         r_tick <= 1'b0;
         if (bus.stop) begin
            r_state <= ST_IDLE;
         end else if (bus.start) begin
            r_state <= ST_RUN;
            r_mode  <= bus.oneshot;
`ifdef TICK_TIMER_STATUS_EN
            r_tick_cnt <= '0;
`endif
         end else if (w_wrap) begin
            r_tick <= 1'b1;
`ifdef TICK_TIMER_STATUS_EN
            r_tick_cnt <= r_tick_cnt + TickCntWidth'(1);
`endif
            if (r_mode) begin
               r_state <= ST_DONE;
            end
         end
      end
   end

   assign bus.count = w_count;
   assign bus.tick  = r_tick;
   assign bus.busy  = (r_state == ST_RUN);
   assign bus.done  = (r_state == ST_DONE);
`ifdef TICK_TIMER_STATUS_EN
   assign bus.tick_cnt = r_tick_cnt;
`endif

endmodule

// File: tb/tb_tick_timer.sv
// Self-checking bench for tick_timer: vector table plus hand-written sequences,
// expected outputs queued at drive time and compared after the clock edge.
module tb_tick_timer;

   localparam int unsigned W = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

`ifdef TICK_TIMER_STATUS_EN
   tick_timer_if #(.Width(W), .TickCntWidth(2)) bus ();
   tick_timer #(.Width(W), .DefaultPeriod(3), .TickCntWidth(2)) dut (
`else
   tick_timer_if #(.Width(W)) bus ();
   tick_timer #(.Width(W), .DefaultPeriod(3)) dut (
`endif
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   typedef struct {
      logic         rst;
      logic         start;
      logic         stop;
      logic         oneshot;
      logic         we;
      logic [W-1:0] pin;
      logic [W-1:0] count;
      logic         tick;
      logic         busy;
      logic         done;
   } vec_t;

   typedef struct {
      logic [W-1:0] count;
      logic         tick;
      logic         busy;
      logic         done;
      string        name;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   function automatic vec_t mk(input logic r, input logic st, input logic sp, input logic os,
                               input logic we, input logic [W-1:0] pin, input logic [W-1:0] c,
                               input logic t, input logic b, input logic d);
      vec_t v;
      v.rst = r; v.start = st; v.stop = sp; v.oneshot = os; v.we = we; v.pin = pin;
      v.count = c; v.tick = t; v.busy = b; v.done = d;
      return v;
   endfunction

   // Drive one cycle of inputs; expected outputs refer to the cycle after the edge.
   task automatic apply(input vec_t v, input string name);
      exp_t e;
      rst           = v.rst;
      bus.start     = v.start;
      bus.stop      = v.stop;
      bus.oneshot   = v.oneshot;
      bus.period_we = v.we;
      bus.period_in = v.pin;
      e.count = v.count; e.tick = v.tick; e.busy = v.busy; e.done = v.done; e.name = name;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if (bus.count !== e.count || bus.tick !== e.tick || bus.busy !== e.busy ||
          bus.done !== e.done) begin
         failures++;
         $display("FAIL %s: got count=%0d tick=%b busy=%b done=%b, want count=%0d tick=%b busy=%b done=%b",
                  e.name, bus.count, bus.tick, bus.busy, bus.done,
                  e.count, e.tick, e.busy, e.done);
      end
      rst = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; bus.oneshot = 1'b0;
      bus.period_we = 1'b0; bus.period_in = '0;
   endtask

   task automatic idle(input logic [W-1:0] c, input logic t, input logic b, input logic d,
                       input string name);
      apply(mk(0, 0, 0, 0, 0, '0, c, t, b, d), name);
   endtask

`ifdef TICK_TIMER_STATUS_EN
   task automatic check_tc(input logic [1:0] want, input string name);
      checks++;
      if (bus.tick_cnt !== want) begin
         failures++;
         $display("FAIL %s: got tick_cnt=%0d, want %0d", name, bus.tick_cnt, want);
      end
   endtask
`endif

   vec_t tbl[14];

   initial begin
      // Default period 3, periodic: ticks at cycles 5, 9, 13
      tbl[0] = mk(1, 0, 0, 0, 0, '0, 0, 0, 0, 0);
      tbl[1] = mk(0, 1, 0, 0, 0, '0, 0, 0, 1, 0);
      for (int i = 2; i < 14; i++) begin
         tbl[i] = mk(0, 0, 0, 0, 0, '0, W'((i - 1) % 4), ((i - 1) % 4) == 0, 1, 0);
      end

      bus.start = 0; bus.stop = 0; bus.oneshot = 0; bus.period_we = 0; bus.period_in = '0;

      for (int i = 0; i < 14; i++) apply(tbl[i], $sformatf("table[%0d]", i));

      // Restart in RUN at count==P cancels the pending wrap
      idle(1, 0, 1, 0, "pre_restart1");
      idle(2, 0, 1, 0, "pre_restart2");
      idle(3, 0, 1, 0, "pre_restart3");
      apply(mk(0, 1, 0, 0, 0, '0, 0, 0, 1, 0), "restart_cancels_wrap");
      apply(mk(0, 0, 1, 0, 0, '0, 0, 0, 0, 0), "stop_idle");

      // P = 0: tick every cycle from cycle 2
      apply(mk(0, 0, 0, 0, 1, 8'd0, 0, 0, 0, 0), "write_p0");
      apply(mk(0, 1, 0, 0, 0, '0, 0, 0, 1, 0), "p0_start");
      for (int i = 0; i < 5; i++) idle(0, 1, 1, 0, $sformatf("p0_tick%0d", i));

      // One-shot, P = 4
      apply(mk(0, 0, 1, 0, 0, '0, 0, 0, 0, 0), "p0_stop");
      apply(mk(0, 0, 0, 0, 1, 8'd4, 0, 0, 0, 0), "write_p4");
      apply(mk(0, 1, 0, 1, 0, '0, 0, 0, 1, 0), "oneshot_start");
      for (int i = 1; i <= 4; i++) idle(W'(i), 0, 1, 0, $sformatf("oneshot_cnt%0d", i));
      idle(0, 1, 0, 1, "oneshot_tick_done");
      for (int i = 0; i < 20; i++) idle(0, 0, 0, 1, $sformatf("done_hold%0d", i));
      apply(mk(0, 1, 0, 0, 0, '0, 0, 0, 1, 0), "done_restart");

      // P = 10, shrink to 2 while count = 7
      apply(mk(0, 0, 1, 0, 1, 8'd10, 0, 0, 0, 0), "stop_write_p10");
      apply(mk(0, 1, 0, 0, 0, '0, 0, 0, 1, 0), "p10_start");
      for (int i = 1; i <= 7; i++) idle(W'(i), 0, 1, 0, $sformatf("p10_cnt%0d", i));
      apply(mk(0, 0, 0, 0, 1, 8'd2, 8, 0, 1, 0), "shrink_write");
      idle(0, 1, 1, 0, "shrink_wrap");
      idle(1, 0, 1, 0, "p2_cnt1");
      idle(2, 0, 1, 0, "p2_cnt2");
      idle(0, 1, 1, 0, "p2_tick");
      apply(mk(0, 1, 1, 0, 0, '0, 0, 0, 0, 0), "start_stop_together");

      // Start with coincident write, then reset mid-run at count = 5
      apply(mk(0, 1, 0, 0, 1, 8'd10, 0, 0, 1, 0), "start_with_write");
      for (int i = 1; i <= 5; i++) idle(W'(i), 0, 1, 0, $sformatf("pre_rst_cnt%0d", i));
      apply(mk(1, 0, 0, 0, 0, '0, 0, 0, 0, 0), "rst_mid_run");
      apply(mk(0, 1, 0, 0, 0, '0, 0, 0, 1, 0), "post_rst_start");
      for (int i = 1; i <= 3; i++) idle(W'(i), 0, 1, 0, $sformatf("post_rst_cnt%0d", i));
      idle(0, 1, 1, 0, "post_rst_default_period");

      // Largest legal period 2^W - 1
      apply(mk(0, 0, 1, 0, 1, 8'd255, 0, 0, 0, 0), "write_pmax");
      apply(mk(0, 1, 0, 0, 0, '0, 0, 0, 1, 0), "pmax_start");
      for (int i = 1; i <= 255; i++) idle(W'(i), 0, 1, 0, "pmax_count");
      idle(0, 1, 1, 0, "pmax_wrap");
      apply(mk(0, 0, 1, 0, 0, '0, 0, 0, 0, 0), "pmax_stop");

`ifdef TICK_TIMER_STATUS_EN
      // Two-bit tick counter wraps 1,2,3,0,1; kept by stop, cleared by start
      apply(mk(1, 0, 0, 0, 0, '0, 0, 0, 0, 0), "tc_rst");
      check_tc(2'd0, "tc_after_rst");
      apply(mk(0, 0, 0, 0, 1, 8'd0, 0, 0, 0, 0), "tc_write_p0");
      apply(mk(0, 1, 0, 0, 0, '0, 0, 0, 1, 0), "tc_start");
      check_tc(2'd0, "tc_start");
      for (int i = 1; i <= 5; i++) begin
         idle(0, 1, 1, 0, "tc_tick");
         check_tc(2'(i), $sformatf("tc_seq%0d", i));
      end
      apply(mk(0, 0, 1, 0, 0, '0, 0, 0, 0, 0), "tc_stop");
      check_tc(2'd1, "tc_kept_by_stop");
      apply(mk(0, 1, 0, 0, 0, '0, 0, 0, 1, 0), "tc_restart");
      check_tc(2'd0, "tc_cleared_by_start");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/tick_timer.md
# tick_timer

- Parametrised, runtime-programmable timer for one clock domain.
- Generates single-cycle `tick` strobes every `period_q + 1` cycles, in either periodic or one-shot mode.
- Has start/stop control and busy/done status.
- Sits between the system clock and slower consumers: display refresh, debouncers, LED blinkers.

## Interface

Parameters:
- `Width`, 25: width of counter, period register and `period_in`.
- `DefaultPeriod`, 25000000: period register value after reset; must fit in `Width` bits.
- `TickCntWidth`, 8: width of `tick_cnt`; exists only with `TICK_TIMER_STATUS_EN`.

Ports:
- `clk` input 1: single clock; all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: start or restart the timer.
- `stop` input 1: return to idle.
- `oneshot` input 1: mode, sampled only with an accepted `start`; 1 = one-shot, 0 = periodic.
- `period_we` input 1: write `period_in` into the period register.
- `period_in` input `Width`: new period value P.
- `count` output `Width`: current counter value.
- `tick` output 1: registered single-cycle strobe on each wrap.
- `busy` output 1: high in RUN.
- `done` output 1: high in DONE.
- `tick_cnt` output `TickCntWidth`: wrapping tick counter; exists only with `TICK_TIMER_STATUS_EN`.

## Operation

States:
- IDLE: `count` = 0, no ticks.
- RUN: `count` increments by 1 per cycle.
- DONE: one-shot finished, `count` held at 0.

Transitions, priority high to low:
- `rst`: state IDLE, `count` 0, `tick` 0, `period_q` = `DefaultPeriod`, `mode_q` 0, `tick_cnt` 0.
- `stop` in any state: next state IDLE, `count` 0, `tick` 0. `stop` beats a simultaneous `start`.
- `start` in any state: next state RUN, `count` 0, `mode_q` <= `oneshot`, `tick` 0.
  - In RUN this is a restart and cancels any pending wrap.
- RUN with `count >= period_q`: `tick` 1 next cycle, `count` 0.
  - If `mode_q` = 1, next state DONE; otherwise stay in RUN.
- RUN otherwise: `count` <= `count` + 1.

Period register:
- `period_we` updates `period_q` next cycle, in any state.
- The `>=` compare handles a new period below the running count: wrap occurs on the next cycle.

Width and value rules:
- P = 0 gives a tick every cycle in RUN.
- P = 2^Width − 1 is legal. The compare precedes the increment, so `count` never overflows.
- Status outputs: `busy` = (state == RUN), `done` = (state == DONE). Both derive directly from the state register.

## Timing

Cycle numbering: `start` is high in cycle 0 from IDLE.
- Cycle 1: RUN, `count` = 0, `busy` = 1.
- Cycle 1+P: `count` = P.
- Cycle 2+P: `tick` = 1, `count` = 0.
- Periodic mode: later ticks every P+1 cycles.
- One-shot mode: cycle 2+P also shows `done` = 1 and `busy` = 0, with `tick` high in that same cycle.

Other timing rules:
- `tick` is never high for two consecutive cycles unless P = 0.
- `tick` is always 0 in the cycle after `rst`, `stop` or `start`.
- `period_we` in cycle n: the compare uses the new value from cycle n+1.
- `period_we` coincident with `start`: both take effect; the first period uses the new value.

## Configuration

`TICK_TIMER_STATUS_EN` defined:
- Adds the `tick_cnt` port and register.
- `tick_cnt` increments, wrapping modulo 2^`TickCntWidth`, in the same cycle `tick` is high.
- Cleared by `rst` and by any accepted `start`. Not cleared by `stop`.

`TICK_TIMER_STATUS_EN` undefined:
- Port and register are absent.
- All other behaviour is identical.

## Structure

Package `tick_timer_pkg` holds:
- `tick_state_e` enum: `ST_IDLE`, `ST_RUN`, `ST_DONE`.
- Default constants for `Width` and `DefaultPeriod`.

Sub-module:
- `mod_counter`: width-parametrised datapath with clear, enable and `>=`-compare wrap; outputs its count and a wrap flag.
- `tick_timer` contains the FSM, period and mode registers, tick register and optional status counter, and instantiates one `mod_counter`.

## Test plan

- Reset with `DefaultPeriod` overridden to 3:
  - Expect `count` = 0, `tick` = 0, `busy` = 0, `done` = 0.
  - Then `start` with `oneshot` = 0: expect ticks at cycles 5, 9, 13, and `count` sequence 0,1,2,3,0.
- `period_in` = 0 via `period_we`, then `start`: expect `tick` high every cycle from cycle 2 on.
- `period_in` = 4, `start` with `oneshot` = 1:
  - Expect a single tick at cycle 6, coincident with `done` = 1 and `busy` = 0.
  - No further ticks for 20 cycles.
  - A new `start` then returns to RUN.
- P = 10, running, `count` = 7:
  - Write P = 2: expect a tick on the cycle after the write takes effect.
  - `start` and `stop` together: expect IDLE, `count` 0.
- `rst` asserted mid-RUN at `count` = 5: expect all outputs at reset values the next cycle.
  - With `TICK_TIMER_STATUS_EN`, `TickCntWidth` = 2, P = 0: expect `tick_cnt` sequence 1,2,3,0,1.
